// File: rtl/uncenter_decide.sv
// Shifts signed centred lanes back to the unsigned [0,1] range, takes hard decisions
// and counts how many consecutive blocks repeat the same decision vector.
module uncenter_decide #(
  parameter int TAG_WIDTH    = 32,
  parameter int BLOCKLENGTH  = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int STABLE_LIMIT = 3,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in,
  input  logic                            clear_history,
  input  logic                            ready_in,
  output logic                            valid_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
  output logic [BLOCKLENGTH-1:0]          decision_out,
  output logic [COUNT_WIDTH-1:0]          stable_count_out,
  output logic                            converged_out,
  output logic                            busy
);

  localparam int QUARTER = 2 ** (DATA_WIDTH - 2);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] LIMIT     = COUNT_WIDTH'(STABLE_LIMIT);

  // Adds one quarter of full scale and clamps to [0, 2^(DATA_WIDTH-1)].
  function automatic logic [DATA_WIDTH-1:0] uncenter_lane(input logic signed [DATA_WIDTH-1:0] c);
    int c_int;
    c_int = int'(c);
    if (c_int < -QUARTER) begin
      uncenter_lane = '0;
    end else if (c_int > QUARTER) begin
      uncenter_lane = DATA_WIDTH'(2 * QUARTER);
    end else begin
      uncenter_lane = DATA_WIDTH'(c_int + QUARTER);
    end
  endfunction

  logic                              s0_valid_r;
  logic [TAG_WIDTH-1:0]              s0_tag_r;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] s0_data_r;
  logic                              s1_valid_r;
  logic [TAG_WIDTH-1:0]              s1_tag_r;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] s1_data_r;
  logic [BLOCKLENGTH-1:0]            s1_dec_r;
  logic [BLOCKLENGTH-1:0]            hist_r;
  logic                              hist_valid_r;
  logic [COUNT_WIDTH-1:0]            count_r;
  logic                              conv_r;

  logic                              enable_s;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] lane_out_s;
  logic [BLOCKLENGTH-1:0]            dec_s;
  logic [COUNT_WIDTH-1:0]            count_nxt_s;

  assign enable_s = ready_in || !s1_valid_r;

  // Per-lane uncentring and hard decision of the stage-0 block.
  always_comb begin
    lane_out_s = '0;
    dec_s      = '0;
    for (int k = 0; k < BLOCKLENGTH; k++) begin
      lane_out_s[k*DATA_WIDTH +: DATA_WIDTH] = uncenter_lane(signed'(s0_data_r[k*DATA_WIDTH +: DATA_WIDTH]));
      dec_s[k] = (signed'(s0_data_r[k*DATA_WIDTH +: DATA_WIDTH]) > signed'({DATA_WIDTH{1'b0}}));
    end
  end

  // Stable count for the block entering stage 1; a coincident clear makes it a first block.
  always_comb begin
    count_nxt_s = '0;
    if (clear_history || !hist_valid_r) begin
      count_nxt_s = '0;
    end else if (dec_s == hist_r) begin
      count_nxt_s = (count_r == COUNT_MAX) ? count_r : count_r + 1'b1;
    end else begin
      count_nxt_s = '0;
    end
  end

  // Pipeline stages, decision history and stable counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_r   <= 1'b0;
      s0_tag_r     <= '0;
      s0_data_r    <= '0;
      s1_valid_r   <= 1'b0;
      s1_tag_r     <= '0;
      s1_data_r    <= '0;
      s1_dec_r     <= '0;
      hist_r       <= '0;
      hist_valid_r <= 1'b0;
      count_r      <= '0;
      conv_r       <= 1'b0;
    end else begin
      if (enable_s) begin
        s0_valid_r <= valid_in;
        s0_tag_r   <= tag_in;
        s0_data_r  <= data_in;
        s1_valid_r <= s0_valid_r;
        s1_tag_r   <= s0_tag_r;
        s1_data_r  <= lane_out_s;
        s1_dec_r   <= dec_s;
      end
      // Bubbles leave history alone; clear still acts during a stall.
      if (enable_s && s0_valid_r) begin
        hist_r       <= dec_s;
        hist_valid_r <= 1'b1;
        count_r      <= count_nxt_s;
        conv_r       <= (count_nxt_s >= LIMIT);
      end else if (clear_history) begin
        hist_valid_r <= 1'b0;
        count_r      <= '0;
        conv_r       <= 1'b0;
      end
    end
  end

  assign ready_out        = enable_s;
  assign valid_out        = s1_valid_r;
  assign tag_out          = s1_tag_r;
  assign data_out         = s1_data_r;
  assign decision_out     = s1_dec_r;
  assign stable_count_out = count_r;
  assign converged_out    = conv_r;
  assign busy             = s0_valid_r || s1_valid_r;

endmodule
